vigenere_stream: RTL and testbench
==================================

Name: vigenere_stream

Overview:
Parametrised streaming Vigenère cipher, successor to the fixed-key single-byte vigenere_ciph. It encrypts or decrypts an 8-bit ASCII character stream using a programmable key of up to MAX_KEY_LEN shifts. Transfers use valid/ready handshakes on both sides. Case is preserved, and non-alphabetic characters pass through unchanged. It sits between a byte source (UART RX or test driver) and a byte sink.

Parameters:
MAX_KEY_LEN, 16, depth of the key shift memory (2..256)
KEY_IDX_W, 4, clog2(MAX_KEY_LEN); width of the key index and write address

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
key_wr_en  input  1  write key_wr_data into key slot key_wr_addr
key_wr_addr  input  KEY_IDX_W  key slot address
key_wr_data  input  5  shift value 0..25; 26..31 stored as value-26
key_len  input  KEY_IDX_W+1  active key length; 0 treated as 1, >MAX_KEY_LEN treated as MAX_KEY_LEN
mode  input  1  0 = encrypt, 1 = decrypt; sampled per accepted character
restart  input  1  synchronously clear the key index to 0
in_valid  input  1  in_char valid
in_ready  output  1  block can accept in_char
in_char  input  8  input ASCII byte
out_valid  output  1  out_char valid
out_ready  input  1  sink accepts out_char
out_char  output  8  output ASCII byte

Behaviour:
- Reset: out_valid=0, out_char=8'h00, key index=0, all key slots=0 (shift 0 = identity).
- in_ready = !out_valid || out_ready (combinational). An input is accepted when in_valid && in_ready.
- Latency: the result appears registered on out_char/out_valid on the edge that accepts the input, so it is visible the next cycle. Full throughput is 1 char/cycle.
- out_valid clears on the edge where out_valid && out_ready && no new accept.
- While out_valid && !out_ready:
  - out_char holds stable.
  - in_ready=0.
  - The key index does not move.
- Character classes:
  - 'A'..'Z' (8'h41..5A): p = c-'A'. Encrypt gives 'A' + (p+k) mod 26. Decrypt gives 'A' + (p+26-k) mod 26.
  - 'a'..'z': same arithmetic with base 'a'.
  - All other bytes: out_char = in_char.
- k = key[idx]. Mod 26 is done by a single conditional subtract of 26 on a 6-bit sum, with no divider.
- Key index update:
  - It advances only on an accepted alphabetic character.
  - It becomes idx+1, or 0 when idx+1 >= effective key_len.
  - Non-alpha characters do not advance it.
- If key_len is lowered below idx+1, the next advance wraps to 0. The current character still uses key[idx].
- restart with no accept: idx <= 0.
- restart with a simultaneous accept:
  - The character uses key[0].
  - idx <= (alpha ? next-of-0 : 0).
- Key write to the slot in use in the same cycle: the character uses the old value; the new value is used from the next cycle.
- Key writes are allowed at any time and have no handshake.
- rst mid-stream:
  - The pending output is dropped (out_valid=0).
  - The key memory is cleared.
  - idx=0.
  - rst dominates restart and key writes.
- mode may change between characters. Each character uses the mode present on its accept cycle. The key index is shared across modes.

Test Plan:
- Key LEMON (11,4,12,14,13), key_len=5, encrypt, stream "ATTACKATDAWN" with out_ready=1 -> "LXFOPVEFRNHR" at 1 char/cycle, with out_valid one cycle after the first accept.
- Same key, decrypt "LXFOPVEFRNHR" -> "ATTACKATDAWN". Then set mode per char to alternate, and check each char against its own mode.
- Key KEY (10,4,24), key_len=3, encrypt "Hello, World" -> "Rijvs, Uyvjn". ',' and ' ' pass through and do not advance the key index.
- Backpressure: hold out_ready=0 for 3 cycles after the first char.
  - Expect in_ready=0 and out_char stable at 'L'.
  - Release, and the remaining output matches the unstalled run exactly.
- Edge values:
  - key_len=0 with key[0]=25: "abz" -> "zay".
  - key_wr_data=30 stored as 4: 'A' -> 'E'.
  - Wrap at MAX_KEY_LEN, with key_len=MAX_KEY_LEN+5 clamped.
- restart after 2 chars of "ATTACK" (LEMON) -> the third char uses shift 11 ('T'->'E'). Assert rst mid-stream -> out_valid=0 next cycle, and a subsequent 'A' passes through as 'A' (keys cleared).

Source files
------------

// File: rtl/vigenere_stream.sv
// Streaming Vigenere cipher with a programmable key of up to MAX_KEY_LEN shifts.
// Encrypts or decrypts one ASCII byte per cycle behind valid/ready handshakes on both sides.
module vigenere_stream #(
    parameter int MAX_KEY_LEN = 16,
    parameter int KEY_IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_wr_en,
    input  logic [KEY_IDX_W-1:0] key_wr_addr,
    input  logic [4:0]           key_wr_data,
    input  logic [KEY_IDX_W:0]   key_len,
    input  logic                 mode,
    input  logic                 restart,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_char,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_char
);

    localparam logic [KEY_IDX_W:0] MAX_LEN = (KEY_IDX_W + 1)'(MAX_KEY_LEN);
    localparam logic [KEY_IDX_W:0] ONE     = (KEY_IDX_W + 1)'(1);

    logic [4:0]           key_mem [MAX_KEY_LEN];
    logic [KEY_IDX_W-1:0] idx;
    logic [KEY_IDX_W-1:0] cur_idx;
    logic [KEY_IDX_W-1:0] next_idx;
    logic [KEY_IDX_W:0]   eff_len;
    logic [KEY_IDX_W:0]   idx_inc;
    logic                 accept;
    logic                 is_upper;
    logic                 is_lower;
    logic                 is_alpha;
    logic [7:0]           base;
    logic [7:0]           result;
    logic [5:0]           p;
    logic [5:0]           sum;
    logic [5:0]           shifted;
    logic [4:0]           k;
    logic [4:0]           wr_val;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // restart redirects the character being accepted this cycle to key slot 0
    assign cur_idx  = restart ? '0 : idx;
    assign k        = key_mem[cur_idx];
    assign idx_inc  = {1'b0, cur_idx} + ONE;
    assign next_idx = (idx_inc >= eff_len) ? '0 : idx_inc[KEY_IDX_W-1:0];
    assign wr_val   = (key_wr_data >= 5'd26) ? key_wr_data - 5'd26 : key_wr_data;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        eff_len = key_len;
        if (key_len == '0) begin
            eff_len = ONE;
        end else if (key_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    always_comb begin
        is_upper = (in_char >= 8'h41) && (in_char <= 8'h5A);
        is_lower = (in_char >= 8'h61) && (in_char <= 8'h7A);
        is_alpha = is_upper || is_lower;
        base     = is_lower ? 8'h61 : 8'h41;
        // Letters differ from their base only in the low bits, so a 6-bit subtract is exact
        p        = in_char[5:0] - base[5:0];
        sum      = mode ? (p + 6'd26 - {1'b0, k}) : (p + {1'b0, k});
        shifted  = (sum >= 6'd26) ? sum - 6'd26 : sum;
        result   = is_alpha ? base + {2'b00, shifted} : in_char;
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            idx       <= '0;
            // NOTE: the key memory is reset on purpose (shift 0 is the identity), so it lives in flops, not RAM.
            for (int i = 0; i < MAX_KEY_LEN; i++) begin
                key_mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_char  <= result;
                idx       <= is_alpha ? next_idx : cur_idx;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (restart) begin
                    idx <= '0;
                end
            end
            if (key_wr_en) begin
                key_mem[key_wr_addr] <= wr_val;
            end
        end
    end

endmodule

// File: tb/tb_vigenere_stream.sv
// Self-checking bench for vigenere_stream: scoreboard queue fed by a behavioural cipher
// model on every accept, drained by a monitor on every output handshake.
module tb_vigenere_stream;

    localparam int MAXK = 16;
    localparam int IW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_wr_en;
    logic [IW-1:0] key_wr_addr;
    logic [4:0]    key_wr_data;
    logic [IW:0]   key_len;
    logic          mode;
    logic          restart;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_char;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_char;

    vigenere_stream #(.MAX_KEY_LEN(MAXK), .KEY_IDX_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_wr_en   (key_wr_en),
        .key_wr_addr (key_wr_addr),
        .key_wr_data (key_wr_data),
        .key_len     (key_len),
        .mode        (mode),
        .restart     (restart),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_char    (out_char)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    string      got   = "";
    logic [7:0] expq[$];
    int         mkey[MAXK];
    int         midx  = 0;
    int         m_cur;
    int         m_eff;
    int         m_out;
    logic [7:0] m_exp;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic bit is_letter(input int c);
        return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
    endfunction

    // Textbook Vigenere on one character: shift letters within their own case, leave the rest
    function automatic int cipher(input int c, input int k, input bit dec);
        int b;
        if (!is_letter(c)) return c;
        b = (c <= 90) ? 65 : 97;
        return dec ? b + (c - b + 26 - k) % 26 : b + (c - b + k) % 26;
    endfunction

    // Monitor pops on each output handshake; reference model pushes on each accept
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            midx = 0;
            foreach (mkey[i]) mkey[i] = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: got %0d with nothing expected", out_char);
                end else begin
                    m_exp = expq.pop_front();
                    check("out_char", out_char, m_exp);
                    got = $sformatf("%s%c", got, out_char);
                end
            end
            if (in_valid && in_ready) begin
                m_cur = restart ? 0 : midx;
                m_eff = (key_len == 0) ? 1 : ((key_len > MAXK) ? MAXK : int'(key_len));
                m_out = cipher(int'(in_char), mkey[m_cur], mode);
                expq.push_back(8'(m_out));
                if (is_letter(int'(in_char))) midx = (m_cur + 1 >= m_eff) ? 0 : m_cur + 1;
                else midx = m_cur;
            end else if (restart) begin
                midx = 0;
            end
            if (key_wr_en) mkey[key_wr_addr] = (key_wr_data >= 26) ? key_wr_data - 26 : key_wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic m);
        int   n;
        logic acc;
        in_valid = 1'b1;
        in_char  = c;
        mode     = m;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) check("accept_timeout", n, 0);
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input logic m);
        for (int i = 0; i < s.len(); i++) send(s[i], m);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("drain_left", expq.size(), 0);
    endtask

    task automatic write_key(input int a, input int d);
        key_wr_en   = 1'b1;
        key_wr_addr = IW'(a);
        key_wr_data = 5'(d);
        tick();
        key_wr_en   = 1'b0;
    endtask

    task automatic load_lemon();
        write_key(0, 11);
        write_key(1, 4);
        write_key(2, 12);
        write_key(3, 14);
        write_key(4, 13);
        key_len = 5;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    t0;
        bit    done;
        string lemon;
        rst = 1'b1; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0; key_len = '0;
        mode = 1'b0; restart = 1'b0; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);

        // LEMON encrypt at full rate
        load_lemon();
        lemon = "ATTACKATDAWN";
        got = "";
        t0 = cyc;
        send(lemon[0], 1'b0);
        check("first_out_valid", out_valid, 1);
        check("first_out_char", out_char, 8'h4C);
        for (int i = 1; i < lemon.len(); i++) send(lemon[i], 1'b0);
        check("throughput_cycles", cyc - t0, 12);
        drain();
        check_str("lemon_enc", got, "LXFOPVEFRNHR");

        // LEMON decrypt, then alternating per-character mode
        pulse_restart();
        got = "";
        send_str("LXFOPVEFRNHR", 1'b1);
        drain();
        check_str("lemon_dec", got, "ATTACKATDAWN");
        pulse_restart();
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 1) ? $urandom_range(65, 90) : $urandom_range(97, 122)), 1'(i % 2));
        end
        drain();

        // KEY with punctuation passing through
        write_key(0, 10);
        write_key(1, 4);
        write_key(2, 24);
        key_len = 3;
        pulse_restart();
        got = "";
        send_str("Hello, World", 1'b0);
        drain();
        check_str("key_hello", got, "Rijvs, Uyvjn");

        // Backpressure: stalled output must hold and block input
        load_lemon();
        pulse_restart();
        got = "";
        out_ready = 1'b0;
        send("A", 1'b0);
        in_valid = 1'b1;
        in_char  = "T";
        mode     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_char", out_char, 8'h4C);
            check("stall_out_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        send_str("TTACKATDAWN", 1'b0);
        drain();
        check_str("stall_stream", got, "LXFOPVEFRNHR");

        // key_len 0 acts as 1
        write_key(0, 25);
        key_len = 0;
        pulse_restart();
        got = "";
        send_str("abz", 1'b0);
        drain();
        check_str("keylen0", got, "zay");

        // Out-of-range shift folds down by 26
        write_key(0, 30);
        key_len = 1;
        got = "";
        send("A", 1'b0);
        drain();
        check_str("wrdata30", got, "E");

        // Oversized key_len clamps to MAX_KEY_LEN
        for (int i = 0; i < MAXK; i++) write_key(i, i + 1);
        key_len = MAXK + 5;
        pulse_restart();
        got = "";
        for (int i = 0; i < 20; i++) send("A", 1'b0);
        drain();
        check_str("wrap_clamp", got, "BCDEFGHIJKLMNOPQBCDE");

        // restart coinciding with an accept
        load_lemon();
        pulse_restart();
        got = "";
        send("A", 1'b0);
        send("T", 1'b0);
        restart = 1'b1;
        send("T", 1'b0);
        restart = 1'b0;
        send("A", 1'b0);
        drain();
        check_str("restart_accept", got, "LXEE");

        // Randomised traffic: bytes, modes, key writes, key_len, restart, gaps, backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    key_len     = 5'($urandom_range(0, 31));
                    restart     = ($urandom_range(0, 15) == 0);
                    key_wr_en   = ($urandom_range(0, 3) == 0);
                    key_wr_addr = IW'($urandom_range(0, MAXK - 1));
                    key_wr_data = 5'($urandom_range(0, 31));
                    if ($urandom_range(0, 9) < 7)
                        send(8'($urandom_range(0, 1) ? $urandom_range(65, 90) : $urandom_range(97, 122)),
                             1'($urandom_range(0, 1)));
                    else
                        send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                    restart   = 1'b0;
                    key_wr_en = 1'b0;
                    if ($urandom_range(0, 3) == 0) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // rst mid-stream drops the pending output and clears keys; rst beats a key write
        load_lemon();
        pulse_restart();
        out_ready = 1'b0;
        send("A", 1'b0);
        check("pending_out_valid", out_valid, 1);
        rst         = 1'b1;
        key_wr_en   = 1'b1;
        key_wr_addr = '0;
        key_wr_data = 5'd5;
        tick();
        check("midrst_out_valid", out_valid, 0);
        rst       = 1'b0;
        key_wr_en = 1'b0;
        out_ready = 1'b1;
        got = "";
        send("A", 1'b0);
        drain();
        check_str("after_rst", got, "A");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
